spi_cmd_ctrl: RTL

- Command and response controller between the 32-bit SPI slave parallel interface and the measurement state machine/counter.
- Decodes received frames into register writes, register reads, start and abort commands.
- Captures each measurement result into a result register with sticky flags.
- Loads response words into the SPI slave TX path through the wren/wr_ack handshake, and raises an interrupt when a result is ready.

---
 rtl/spi_cmd_pkg.sv | 58 +++++
 rtl/spi_tx_loader.sv | 68 ++++++
 rtl/spi_cmd_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared constants and types for the SPI command controller.
//   - opcode and register address constants
//   - STATUS byte bit indices and frame field offsets
//   - command FSM and TX handshake FSM state encodings
//   - helpers: STATUS byte packing and frame parity check (the parity
//     check is only used when SPI_CMD_PARITY_EN is defined)
package spi_cmd_pkg;

  // Opcodes, frame bits [31:28]
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_WRITE  = 4'd1;
  localparam logic [3:0] OP_READ   = 4'd2;
  localparam logic [3:0] OP_START  = 4'd3;
  localparam logic [3:0] OP_ABORT  = 4'd4;
  localparam logic [3:0] OP_PARERR = 4'hF;  // response opcode for a parity-rejected frame

  // Register addresses, frame bits [27:24]
  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_LIMIT  = 4'd1;
  localparam logic [3:0] ADDR_STATUS = 4'd2;
  localparam logic [3:0] ADDR_RESULT = 4'd3;

  // STATUS byte bit indices; bits [2:0] hold the range of the last result
  localparam int ST_RESULT_VALID = 7;
  localparam int ST_OVERRUN      = 6;
  localparam int ST_CMD_DROP     = 5;
  localparam int ST_START_REJ    = 4;
  localparam int ST_CMD_ERR      = 3;

  // Frame field offsets
  localparam int FR_OP_LSB   = 28;
  localparam int FR_ADDR_LSB = 24;
  localparam int FR_PARITY   = 23;
  localparam int FR_DATA_LSB = 0;

  typedef enum logic {CMD_IDLE, CMD_EXEC} cmd_state_e;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_e;

  function automatic logic [7:0] pack_status(input logic valid, input logic overrun,
                                             input logic drop, input logic rej,
                                             input logic err, input logic [2:0] rng);
    logic [7:0] s;
    s = 8'h00;
    s[ST_RESULT_VALID] = valid;
    s[ST_OVERRUN]      = overrun;
    s[ST_CMD_DROP]     = drop;
    s[ST_START_REJ]    = rej;
    s[ST_CMD_ERR]      = err;
    s[2:0]             = rng;
    return s;
  endfunction

  // Even parity over opcode, addr, parity bit and data: all 25 bits XOR to 0.
  function automatic logic frame_parity_ok(input logic [31:0] f);
    return (^{f[31:FR_PARITY], f[15:0]}) == 1'b0;
  endfunction

endpackage

// File: rtl/spi_tx_loader.sv
// spi_tx_loader: hands response words to the SPI slave TX path.
//   clk_i, rst_i   clock, synchronous active-high reset
//   tx_req_i       slave di_req (level); a rising edge requests a word
//   resp_i         current response register contents
//   tx_ack_i       slave write acknowledge
//   tx_data_o      word presented to the slave, held while tx_wren_o=1
//   tx_wren_o      write enable, held until tx_ack_i, drops the cycle after
module spi_tx_loader
  import spi_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_req_i,
  input  logic [31:0] resp_i,
  input  logic        tx_ack_i,
  output logic [31:0] tx_data_o,
  output logic        tx_wren_o
);

  tx_state_e   state_q, state_d;
  logic        req_q;
  logic [31:0] data_q, data_d;
  logic        wren_q, wren_d;
  logic        req_rise;

  assign req_rise  = tx_req_i & ~req_q;
  assign tx_data_o = data_q;
  assign tx_wren_o = wren_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      req_q   <= 1'b0;
      data_q  <= 32'h0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= tx_req_i;
      data_q  <= data_d;
      wren_q  <= wren_d;
    end
  end

  // The data register only loads from TX_IDLE, so response updates while a
  // word is waiting for its ack never disturb the word on the bus.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wren_d  = wren_q;
    case (state_q)
      TX_IDLE: begin
        if (req_rise) begin
          data_d  = resp_i;
          wren_d  = 1'b1;
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_ack_i) begin
          wren_d  = 1'b0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command/response controller between the SPI slave parallel
// interface and the measurement engine.
//   clk_i, rst_i          clock, synchronous active-high reset
//   rx_valid_i, rx_data_i received frame strobe and 32-bit frame
//   tx_req_i, tx_ack_i    slave TX request / acknowledge
//   tx_data_o, tx_wren_o  response word and write enable to the slave
//   meas_*_i              measurement done pulse, count, range, range error, busy
//   meas_start_o/abort_o  single-cycle command pulses
//   mode_sel_o, limit_o   CTRL mode field and LIMIT register
//   irq_o                 result-ready interrupt (result_valid & irq_en, registered)
// Build option: define SPI_CMD_PARITY_EN to enforce even parity on frame bit 23.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter logic [15:0] LIMIT_RST = 16'd1000,
  parameter logic [1:0]  MODE_RST  = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [31:0] rx_data_i,
  input  logic        tx_req_i,
  output logic [31:0] tx_data_o,
  output logic        tx_wren_o,
  input  logic        tx_ack_i,
  input  logic        meas_done_i,
  input  logic [15:0] meas_count_i,
  input  logic [2:0]  meas_range_i,
  input  logic        meas_range_err_i,
  input  logic        meas_busy_i,
  output logic        meas_start_o,
  output logic        meas_abort_o,
  output logic [1:0]  mode_sel_o,
  output logic [15:0] limit_o,
  output logic        irq_o
);

  cmd_state_e  state_q, state_d;
  logic [31:0] frame_q;
  logic [31:0] resp_q, resp_d;
  logic [1:0]  mode_q, mode_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] limit_q, limit_d;
  logic        valid_q, valid_d, overrun_q, overrun_d, drop_q, drop_d;
  logic        rej_q, rej_d, err_q, err_d;
  logic [2:0]  range_q, range_d;
  logic        rerr_q, rerr_d;
  logic [15:0] result_q, result_d;
  logic        start_q, start_d, abort_q, abort_d, irq_q;

  logic [3:0]  op, addr;
  logic [15:0] data;
  logic        exec;
  logic [15:0] rd_data;
  logic        rd_result, par_bad;
  logic        unused_frame_bits;

  assign op    = frame_q[FR_OP_LSB +: 4];
  assign addr  = frame_q[FR_ADDR_LSB +: 4];
  assign data  = frame_q[FR_DATA_LSB +: 16];
  assign exec  = (state_q == CMD_EXEC);
  assign unused_frame_bits = ^frame_q[23:16];

  assign mode_sel_o   = mode_q;
  assign limit_o      = limit_q;
  assign meas_start_o = start_q;
  assign meas_abort_o = abort_q;
  assign irq_o        = irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CMD_IDLE;
      frame_q  <= 32'h0;
      resp_q   <= 32'h0;
      mode_q   <= MODE_RST;
      irq_en_q <= 1'b0;
      limit_q  <= LIMIT_RST;
      valid_q  <= 1'b0;
      overrun_q <= 1'b0;
      drop_q   <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 1'b0;
      range_q  <= 3'd0;
      rerr_q   <= 1'b0;
      result_q <= 16'h0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (state_q == CMD_IDLE && rx_valid_i) frame_q <= rx_data_i;
      resp_q   <= resp_d;
      mode_q   <= mode_d;
      irq_en_q <= irq_en_d;
      limit_q  <= limit_d;
      valid_q  <= valid_d;
      overrun_q <= overrun_d;
      drop_q   <= drop_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      range_q  <= range_d;
      rerr_q   <= rerr_d;
      result_q <= result_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      irq_q    <= valid_q & irq_en_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    mode_d    = mode_q;
    irq_en_d  = irq_en_q;
    limit_d   = limit_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;
    rej_d     = rej_q;
    err_d     = err_q;
    range_d   = range_q;
    rerr_d    = rerr_q;
    result_d  = result_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    rd_data   = 16'h0;
    rd_result = 1'b0;
    par_bad   = 1'b0;

    case (state_q)
      CMD_IDLE: if (rx_valid_i) state_d = CMD_EXEC;
      CMD_EXEC: state_d = CMD_IDLE;
      default:  state_d = CMD_IDLE;
    endcase

    // Command execution. Read data is the register content at EXEC, before
    // this cycle's flag updates.
    if (exec) begin
`ifdef SPI_CMD_PARITY_EN
      par_bad = ~frame_parity_ok(frame_q);
`endif
      if (par_bad) begin
        err_d = 1'b1;
      end else begin
        case (op)
          OP_NOP: ;
          OP_WRITE: begin
            case (addr)
              ADDR_CTRL: begin
                mode_d   = data[1:0];
                irq_en_d = data[2];
              end
              ADDR_LIMIT: limit_d = data;
              ADDR_STATUS: begin
                if (data[ST_OVERRUN])   overrun_d = 1'b0;
                if (data[ST_CMD_DROP])  drop_d    = 1'b0;
                if (data[ST_START_REJ]) rej_d     = 1'b0;
                if (data[ST_CMD_ERR])   err_d     = 1'b0;
              end
              default: err_d = 1'b1;  // RESULT is read-only; others undefined
            endcase
          end
          OP_READ: begin
            case (addr)
              ADDR_CTRL:   rd_data = {13'h0, irq_en_q, mode_q};
              ADDR_LIMIT:  rd_data = limit_q;
              ADDR_STATUS: rd_data = {rerr_q, 7'h0,
                                      pack_status(valid_q, overrun_q, drop_q, rej_q, err_q, range_q)};
              ADDR_RESULT: begin
                rd_data   = result_q;
                rd_result = 1'b1;
              end
              default:     rd_data = 16'h0;
            endcase
          end
          OP_START: begin
            if (meas_busy_i) rej_d   = 1'b1;
            else             start_d = 1'b1;
          end
          OP_ABORT: abort_d = 1'b1;
          default:  err_d   = 1'b1;
        endcase
      end
    end

    // Result capture. A read of RESULT consumes result_valid, so a capture
    // landing on that same cycle is a fresh result, not an overrun.
    if (rd_result) valid_d = 1'b0;
    if (meas_done_i) begin
      if (valid_q && !rd_result) overrun_d = 1'b1;
      valid_d  = 1'b1;
      result_d = meas_count_i;
      range_d  = meas_range_i;
      rerr_d   = meas_range_err_i;
    end

    // A frame arriving while the previous one executes is lost. The set is
    // placed after the write-1-to-clear so a simultaneous clear cannot hide it.
    if (exec && rx_valid_i) drop_d = 1'b1;

    // Response carries the flags as they stand after this cycle's updates.
    if (exec) begin
      resp_d = {par_bad ? OP_PARERR : op, addr,
                pack_status(valid_d, overrun_d, drop_d, rej_d, err_d, range_d),
                par_bad ? 16'h0 : rd_data};
    end
  end

  spi_tx_loader u_tx_loader (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .tx_req_i  (tx_req_i),
    .resp_i    (resp_q),
    .tx_ack_i  (tx_ack_i),
    .tx_data_o (tx_data_o),
    .tx_wren_o (tx_wren_o)
  );

endmodule
